// File: rtl/sp_ram_init_if.sv
// Access bus for sp_ram_init: cs/we/oe style requests plus ready, read-valid
// and range-error status returned by the memory.
interface sp_ram_init_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned BYTE_W = 8
);
   localparam int unsigned NBE = WIDTH / BYTE_W;

   logic              cs;
   logic              we;
   logic              oe;
   logic [NBE-1:0]    be;
   logic [ADDR_W-1:0] address;
   logic [WIDTH-1:0]  data;
   logic [WIDTH-1:0]  data_out;
   logic              rd_valid;
   logic              err;
   logic              ready;
   logic              init_busy;

   modport master (
      output cs, we, oe, be, address, data,
      input  data_out, rd_valid, err, ready, init_busy
   );

   modport slave (
      input  cs, we, oe, be, address, data,
      output data_out, rd_valid, err, ready, init_busy
   );
endinterface

// File: rtl/sp_ram_init.sv
// Synchronous single-port RAM with byte-lane writes, registered read port,
// selectable read-during-write behaviour and a post-reset clearing sweep.
module sp_ram_init #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BYTE_W    = 8,
   parameter int unsigned READ_MODE = 0,
   parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
   input logic           clk,
   input logic           rst,
   sp_ram_init_if.slave  bus
);
   localparam int unsigned NBE = WIDTH / BYTE_W;
   localparam int unsigned CW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0]   LAST_LOC = CW'(DEPTH - 1);
   localparam logic [ADDR_W:0] DEPTH_A  = (ADDR_W + 1)'(DEPTH);

   localparam logic [0:0] S_INIT = 1'b0;
   localparam logic [0:0] S_IDLE = 1'b1;

   logic [0:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata;
   logic [WIDTH-1:0] old_word;
   logic [WIDTH-1:0] merged;
   logic [CW-1:0]    idx;
   logic             acc;
   logic             in_range;
   logic             rd_valid_q;
   logic             err_q;

   assign idx      = bus.address[CW-1:0];
   assign in_range = {1'b0, bus.address} < DEPTH_A;
   assign acc      = (state == S_IDLE) && bus.cs;
   assign old_word = mem[idx];

   always_comb begin
      merged = old_word;
      for (int unsigned i = 0; i < NBE; i++) begin
         if (bus.be[i]) merged[i*BYTE_W +: BYTE_W] = bus.data[i*BYTE_W +: BYTE_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_INIT;
         cnt        <= '0;
         rdata      <= '0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         rd_valid_q <= acc;
         err_q      <= acc && !in_range;
         if (state == S_INIT) begin
            if (cnt == LAST_LOC) state <= S_IDLE;
            else                 cnt   <= cnt + CW'(1);
         end
         if (acc) begin
            if (!in_range)                         rdata <= '0;
            else if (bus.we && (READ_MODE != 0))   rdata <= merged;
            else                                   rdata <= old_word;
         end
      end
   end

   // Array kept out of the reset block so it maps to plain RAM; reset still
   // blocks any write on its edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == S_INIT)                 mem[cnt] <= INIT_VAL;
         else if (acc && bus.we && in_range)  mem[idx] <= merged;
      end
   end

   assign bus.data_out  = bus.oe ? rdata : '0;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.err       = err_q;
   assign bus.ready     = (state == S_IDLE);
   assign bus.init_busy = (state != S_IDLE);
endmodule

// File: tb/tb_sp_ram_init.sv
// Scoreboard bench for sp_ram_init: two 16-bit instances (read-first and
// write-first) driven in lockstep and compared against a reference array.
module tb_sp_ram_init;
   localparam logic [15:0] INIT = 16'h0000;

   typedef struct {
      logic [15:0] d;
      logic        e;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic oe;
   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [15:0] mdl [16];
   logic [15:0] last0, last1;
   bit          mdl_ready;
   int unsigned mdl_cnt;

   always #5 clk = ~clk;

   sp_ram_init_if #(.WIDTH(16), .ADDR_W(8), .BYTE_W(8)) if0 ();
   sp_ram_init_if #(.WIDTH(16), .ADDR_W(8), .BYTE_W(8)) if1 ();

   sp_ram_init #(.WIDTH(16), .DEPTH(16), .ADDR_W(8), .BYTE_W(8),
                 .READ_MODE(0), .INIT_VAL(INIT)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   sp_ram_init #(.WIDTH(16), .DEPTH(16), .ADDR_W(8), .BYTE_W(8),
                 .READ_MODE(1), .INIT_VAL(INIT)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic mon(input int k, input logic rv, input logic er, input logic [15:0] dout,
                      input logic rdy, input logic busy);
      exp_t e;
      bit   have;
      have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
      check($sformatf("ready%0d", k), {31'd0, rdy}, {31'd0, mdl_ready});
      check($sformatf("busy%0d", k), {31'd0, busy}, {31'd0, !mdl_ready});
      if (have) begin
         if (k == 0) e = q0.pop_front();
         else        e = q1.pop_front();
         if (k == 0) last0 = e.d;
         else        last1 = e.d;
         check($sformatf("rd_valid%0d", k), {31'd0, rv}, 32'd1);
         check($sformatf("err%0d", k), {31'd0, er}, {31'd0, e.e});
      end else begin
         check($sformatf("rd_valid_idle%0d", k), {31'd0, rv}, 32'd0);
         check($sformatf("err_idle%0d", k), {31'd0, er}, 32'd0);
      end
      check($sformatf("data_out%0d", k), {16'd0, dout},
            {16'd0, oe ? ((k == 0) ? last0 : last1) : 16'h0000});
   endtask

   task automatic step(input logic r, input logic c, input logic w, input logic [1:0] b,
                       input logic [7:0] a, input logic [15:0] d);
      exp_t        e0, e1;
      logic [15:0] old, mrg;
      bit          inr;
      rst = r;
      if0.cs = c; if0.we = w; if0.be = b; if0.address = a; if0.data = d;
      if1.cs = c; if1.we = w; if1.be = b; if1.address = a; if1.data = d;
      if (r) begin
         mdl_ready = 0;
         mdl_cnt   = 0;
         last0     = '0;
         last1     = '0;
      end else if (!mdl_ready) begin
         mdl[mdl_cnt] = INIT;
         mdl_cnt++;
         if (mdl_cnt == 16) mdl_ready = 1;
      end else if (c) begin
         inr = (a < 8'd16);
         old = inr ? mdl[a[3:0]] : 16'h0000;
         mrg = old;
         if (b[0]) mrg[7:0]  = d[7:0];
         if (b[1]) mrg[15:8] = d[15:8];
         e0.d = inr ? old : 16'h0000;
         e1.d = inr ? (w ? mrg : old) : 16'h0000;
         e0.e = !inr;
         e1.e = !inr;
         q0.push_back(e0);
         q1.push_back(e1);
         if (inr && w) mdl[a[3:0]] = mrg;
      end
      @(posedge clk);
      #1;
      mon(0, if0.rd_valid, if0.err, if0.data_out, if0.ready, if0.init_busy);
      mon(1, if1.rd_valid, if1.err, if1.data_out, if1.ready, if1.init_busy);
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
      step(1'b0, 1'b1, 1'b1, b, a, d);
   endtask

   task automatic rd(input logic [7:0] a);
      step(1'b0, 1'b1, 1'b0, 2'b00, a, 16'h0000);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 16'h0000);
   endtask

   initial begin
      oe = 1'b1;
      if0.oe = 1'b1;
      if1.oe = 1'b1;
      for (int i = 0; i < 16; i++) mdl[i] = 16'hxxxx;
      step(1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 16'h0000);
      step(1'b1, 1'b1, 1'b1, 2'b11, 8'd0, 16'hFFFF);

      // Sweep with cs held high: nothing may be accepted until ready.
      for (int i = 0; i < 16; i++) wr(8'd0, 16'hFFFF, 2'b11);
      for (int i = 0; i < 16; i++) rd(8'(i));

      wr(8'd0, 16'h005A, 2'b01);
      wr(8'd1, 16'h004B, 2'b01);
      rd(8'd0);
      rd(8'd1);
      idle();
      oe = 1'b0; if0.oe = 1'b0; if1.oe = 1'b0;
      #1;
      check("oe_off0", {16'd0, if0.data_out}, 32'd0);
      check("oe_off1", {16'd0, if1.data_out}, 32'd0);
      oe = 1'b1; if0.oe = 1'b1; if1.oe = 1'b1;
      #1;
      check("oe_on0", {16'd0, if0.data_out}, 32'h004B);
      check("oe_on1", {16'd0, if1.data_out}, 32'h004B);

      wr(8'd3, 16'hABCD, 2'b11);
      wr(8'd3, 16'h1234, 2'b01);
      rd(8'd3);
      wr(8'd3, 16'h9999, 2'b00);
      rd(8'd3);

      wr(8'd0, 16'h0077, 2'b11);
      rd(8'd0);

      wr(8'd4, 16'h0044, 2'b11);
      wr(8'd20, 16'h00FF, 2'b11);
      rd(8'd20);
      rd(8'd4);
      rd(8'd255);

      for (int i = 0; i < 40; i++) begin
         if (($urandom_range(0, 3) == 0)) idle();
         else step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   8'($urandom_range(0, 19)), 16'($urandom));
      end

      wr(8'd0, 16'h005A, 2'b11);
      step(1'b1, 1'b1, 1'b1, 2'b11, 8'd1, 16'h0099);
      for (int i = 0; i < 7; i++) idle();
      step(1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 16'h0000);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 16'h0000);
      rd(8'd0);
      rd(8'd1);
      idle();

      check("q0_drained", q0.size(), 32'd0);
      check("q1_drained", q1.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout at %0t", $time);
      $fatal(1, "timeout");
   end
endmodule
